// File: rtl/sap1_ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sap1_ram_ctrl_pkg
//   Shared definitions for the SAP-1 RAM sequencer: default address/data
//   widths, the run/load mode encoding and the controller state encoding.
//
//   Contents
//     DEF_AW, DEF_DW     default address and data widths (RAM16x8)
//     MODE_LOAD/MODE_RUN values of the 'run' mode-select input
//     state_t            3-bit controller state encoding
//     isRunState()       true for the two CPU-facing states
// ---------------------------------------------------------------------------
package sap1_ram_ctrl_pkg;

    localparam int DEF_AW = 4;
    localparam int DEF_DW = 8;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_RUN  = 1'b1;

    typedef enum logic [2:0] {
        ST_LOAD_IDLE = 3'd0,
        ST_LOAD_WR   = 3'd1,
        ST_DONE      = 3'd2,
        ST_RUN_IDLE  = 3'd3,
        ST_RUN_RD    = 3'd4
    } state_t;

    // The RUN states are the only ones from which a drop of 'run' sends the
    // controller back to loading, which also restarts the load pointer.
    function automatic logic isRunState(input state_t s);
        return (s == ST_RUN_IDLE) || (s == ST_RUN_RD);
    endfunction

endpackage : sap1_ram_ctrl_pkg

// File: rtl/sap1_ram_ctrl_ram_load_ctr.sv
// ---------------------------------------------------------------------------
// ram_load_ctr
//   Load pointer for the SAP-1 RAM sequencer. Holds the address the next
//   loader byte will be written to and flags the last location.
//
//   Ports
//     clk    in   system clock, rising edge
//     i_clr  in   synchronous clear to address 0 (wins over i_inc)
//     i_inc  in   advance the pointer by one (wraps naturally at 2**AW)
//     o_ptr  out  current pointer value
//     o_tc   out  terminal count: pointer sits on the last RAM address
// ---------------------------------------------------------------------------
module ram_load_ctr #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [AW-1:0] o_ptr,
    output logic          o_tc
);

    logic [AW-1:0] r_count;

    // Pointer register. Clear has priority so that a reset or a return to
    // LOAD mode always restarts the image at address 0.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_ptr = r_count;
    assign o_tc  = (r_count == {AW{1'b1}});

endmodule : ram_load_ctr

// File: rtl/sap1_ram_ctrl.sv
// ---------------------------------------------------------------------------
// sap1_ram_ctrl
//   Sequencer in front of the SAP-1 RAM16x8 and the only driver of its
//   write/prog/ce/a/d pins. In LOAD mode it streams loader bytes into
//   addresses 0..2**AW-1 (one byte per two cycles); in RUN mode it serves
//   single-byte CPU reads with a req/ack handshake (ack one cycle after req).
//
//   Ports
//     clk        in   system clock
//     clr        in   synchronous active-high reset
//     run        in   mode select (0 = LOAD, 1 = RUN)
//     ld_valid   in   loader byte valid
//     ld_data    in   loader byte
//     ld_ready   out  byte accepted this cycle (decoded, not registered)
//     ld_done    out  every location written since LOAD was entered
//     cpu_req    in   CPU read request (looked at only in RUN_IDLE)
//     cpu_addr   in   CPU read address (captured with the request)
//     cpu_ack    out  one-cycle pulse, cpu_data valid
//     cpu_data   out  read data, held until the next ack
//     ram_out    in   RAM read data
//     ram_write  out  RAM write strobe
//     ram_prog   out  RAM program-mode select
//     ram_ce     out  RAM read enable
//     ram_a      out  RAM address
//     ram_d      out  RAM write data
// ---------------------------------------------------------------------------
module sap1_ram_ctrl
    import sap1_ram_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          run,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_done,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_data,
    input  logic [DW-1:0] ram_out,
    output logic          ram_write,
    output logic          ram_prog,
    output logic          ram_ce,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d
);

    state_t        r_state;
    logic          r_ldDone;
    logic          r_cpuAck;
    logic [DW-1:0] r_cpuData;
    logic          r_ramWrite;
    logic          r_ramProg;
    logic          r_ramCe;
    logic [AW-1:0] r_ramA;
    logic [DW-1:0] r_ramD;

    logic [AW-1:0] w_ptr;
    logic          w_ptrTc;
    logic          w_ptrClr;
    logic          w_ptrInc;
    logic          w_ldReady;
    logic          w_accept;

    // Handshake and pointer control decoded from the current state.
    // ld_ready is masked by clr so it stays low for the whole reset and
    // first rises on the cycle after clr is released. The pointer advances
    // once per completed write and restarts on reset or whenever a RUN
    // state hands control back to loading.
    always_comb begin
        w_ldReady = (r_state == ST_LOAD_IDLE) && (run == MODE_LOAD) && !clr;
        w_accept  = w_ldReady && ld_valid;
        w_ptrInc  = (r_state == ST_LOAD_WR) && !clr;
        w_ptrClr  = clr || (isRunState(r_state) && (run == MODE_LOAD));
    end

    ram_load_ctr #(
        .AW (AW)
    ) u_loadCtr (
        .clk   (clk),
        .i_clr (w_ptrClr),
        .i_inc (w_ptrInc),
        .o_ptr (w_ptr),
        .o_tc  (w_ptrTc)
    );

    // Controller FSM with all RAM and CPU outputs registered here.
    // The write pulse is issued on entry to LOAD_WR and removed on its exit,
    // so it lasts exactly one cycle; prog is pulsed alongside it, which keeps
    // prog low in every RUN state and lets the RAM drive ram_out during reads.
    // A read is launched from RUN_IDLE (address captured, ce raised) and
    // completed from RUN_RD, where ram_out is captured and ack pulses. A read
    // in flight is always finished even if run drops, and only then does the
    // controller return to LOAD_IDLE with ld_done cleared.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= ST_LOAD_IDLE;
            r_ldDone   <= 1'b0;
            r_cpuAck   <= 1'b0;
            r_cpuData  <= '0;
            r_ramWrite <= 1'b0;
            r_ramProg  <= 1'b0;
            r_ramCe    <= 1'b0;
            r_ramA     <= '0;
            r_ramD     <= '0;
        end else begin
            r_cpuAck <= 1'b0;
            case (r_state)
                ST_LOAD_IDLE: begin
                    if (run == MODE_RUN) begin
                        r_state <= ST_RUN_IDLE;
                    end else if (w_accept) begin
                        r_ramD     <= ld_data;
                        r_ramA     <= w_ptr;
                        r_ramProg  <= 1'b1;
                        r_ramWrite <= 1'b1;
                        r_state    <= ST_LOAD_WR;
                    end
                end

                ST_LOAD_WR: begin
                    r_ramWrite <= 1'b0;
                    r_ramProg  <= 1'b0;
                    if (w_ptrTc) begin
                        r_ldDone <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (run == MODE_RUN) begin
                        r_state <= ST_RUN_IDLE;
                    end else begin
                        r_state <= ST_LOAD_IDLE;
                    end
                end

                ST_DONE: begin
                    if (run == MODE_RUN) begin
                        r_state <= ST_RUN_IDLE;
                    end
                end

                ST_RUN_IDLE: begin
                    r_ramWrite <= 1'b0;
                    r_ramProg  <= 1'b0;
                    if (run == MODE_LOAD) begin
                        r_ldDone <= 1'b0;
                        r_state  <= ST_LOAD_IDLE;
                    end else if (cpu_req) begin
                        r_ramA  <= cpu_addr;
                        r_ramCe <= 1'b1;
                        r_state <= ST_RUN_RD;
                    end
                end

                ST_RUN_RD: begin
                    r_cpuData <= ram_out;
                    r_cpuAck  <= 1'b1;
                    r_ramCe   <= 1'b0;
                    if (run == MODE_LOAD) begin
                        r_ldDone <= 1'b0;
                        r_state  <= ST_LOAD_IDLE;
                    end else begin
                        r_state <= ST_RUN_IDLE;
                    end
                end

                default: begin
                    r_state    <= ST_LOAD_IDLE;
                    r_ramWrite <= 1'b0;
                    r_ramProg  <= 1'b0;
                    r_ramCe    <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready  = w_ldReady;
    assign ld_done   = r_ldDone;
    assign cpu_ack   = r_cpuAck;
    assign cpu_data  = r_cpuData;
    assign ram_write = r_ramWrite;
    assign ram_prog  = r_ramProg;
    assign ram_ce    = r_ramCe;
    assign ram_a     = r_ramA;
    assign ram_d     = r_ramD;

endmodule : sap1_ram_ctrl

// File: tb/tb_sap1_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sap1_ram_ctrl
//   Directed bench for the SAP-1 RAM sequencer. Contains a behavioural
//   RAM16x8 connected to the controller's RAM pins. Inputs change and
//   outputs are checked on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sap1_ram_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          clr;
    logic          run;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_done;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ack;
    logic [DW-1:0] cpu_data;
    logic [DW-1:0] ram_out;
    logic          ram_write;
    logic          ram_prog;
    logic          ram_ce;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;

    int vectors     = 0;
    int miscompares = 0;
    logic monitorOn = 1'b0;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] expRead [8];

    // 2 ns clock period.
    always #1 clk = ~clk;

    sap1_ram_ctrl #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .run       (run),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ack   (cpu_ack),
        .cpu_data  (cpu_data),
        .ram_out   (ram_out),
        .ram_write (ram_write),
        .ram_prog  (ram_prog),
        .ram_ce    (ram_ce),
        .ram_a     (ram_a),
        .ram_d     (ram_d)
    );

    // Behavioural RAM16x8: clocked write in prog mode, combinational read
    // while enabled and not in prog mode.
    always @(posedge clk) begin
        if (ram_prog && ram_write) begin
            mem[ram_a] <= ram_d;
        end
    end

    assign ram_out = (ram_ce && !ram_prog) ? mem[ram_a] : '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iRun, input logic iValid,
                                 input logic [DW-1:0] iData, input logic iReq,
                                 input logic [AW-1:0] iAddr);
        run      = iRun;
        ld_valid = iValid;
        ld_data  = iData;
        cpu_req  = iReq;
        cpu_addr = iAddr;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // RAM pin invariants checked every cycle once reset has settled.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("write_and_ce", {31'd0, ram_write & ram_ce}, 32'd0);
            checkOutput("write_without_prog", {31'd0, ram_write & ~ram_prog}, 32'd0);
        end
    end

    initial begin
        clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);

        // Reset held for three cycles: every output low.
        tick(); tick(); tick();
        checkOutput("rst_ld_ready",  {31'd0, ld_ready},  32'd0);
        checkOutput("rst_ld_done",   {31'd0, ld_done},   32'd0);
        checkOutput("rst_cpu_ack",   {31'd0, cpu_ack},   32'd0);
        checkOutput("rst_cpu_data",  {24'd0, cpu_data},  32'd0);
        checkOutput("rst_ram_write", {31'd0, ram_write}, 32'd0);
        checkOutput("rst_ram_prog",  {31'd0, ram_prog},  32'd0);
        checkOutput("rst_ram_ce",    {31'd0, ram_ce},    32'd0);
        checkOutput("rst_ram_a",     {28'd0, ram_a},     32'd0);
        checkOutput("rst_ram_d",     {24'd0, ram_d},     32'd0);
        clr = 1'b0;
        monitorOn = 1'b1;
        tick();
        checkOutput("rel_ld_ready", {31'd0, ld_ready}, 32'd1);

        // Full 16-byte image A0..AF with ld_valid held high.
        $display("[TB] full image load");
        for (int i = 0; i < 16; i++) begin
            checkOutput("ld_ready_idle", {31'd0, ld_ready}, 32'd1);
            applyStimulus(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, 4'd0);
            tick();
            checkOutput("ld_ready_wr", {31'd0, ld_ready},  32'd0);
            checkOutput("ld_write",    {31'd0, ram_write}, 32'd1);
            checkOutput("ld_prog",     {31'd0, ram_prog},  32'd1);
            checkOutput("ld_addr",     {28'd0, ram_a},     32'(i));
            checkOutput("ld_data",     {24'd0, ram_d},     32'h0A0 + 32'(i));
            checkOutput("ld_done_mid", {31'd0, ld_done},   32'd0);
            tick();
            checkOutput("ld_write_off", {31'd0, ram_write}, 32'd0);
        end
        checkOutput("ld_done_full", {31'd0, ld_done}, 32'd1);
        checkOutput("ld_ready_done", {31'd0, ld_ready}, 32'd0);
        tick(); tick();
        checkOutput("ld_ready_done2", {31'd0, ld_ready},  32'd0);
        checkOutput("done_no_write",  {31'd0, ram_write}, 32'd0);

        // Single read of address 5.
        $display("[TB] run mode reads");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 4'd5);
        tick();
        checkOutput("rd5_ce",   {31'd0, ram_ce},   32'd1);
        checkOutput("rd5_prog", {31'd0, ram_prog}, 32'd0);
        checkOutput("rd5_ack0", {31'd0, cpu_ack},  32'd0);
        checkOutput("rd5_addr", {28'd0, ram_a},    32'd5);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd9);
        tick();
        checkOutput("rd5_ack",  {31'd0, cpu_ack},  32'd1);
        checkOutput("rd5_data", {24'd0, cpu_data}, 32'h0A5);
        checkOutput("rd5_ce_off", {31'd0, ram_ce}, 32'd0);
        tick();
        checkOutput("rd5_ack_off", {31'd0, cpu_ack},  32'd0);
        checkOutput("rd5_hold",    {24'd0, cpu_data}, 32'h0A5);

        // Back-to-back reads with cpu_req held: one ack every two cycles.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 4'(i));
            tick();
            checkOutput("stream_ce",   {31'd0, ram_ce},  32'd1);
            checkOutput("stream_ack0", {31'd0, cpu_ack}, 32'd0);
            tick();
            checkOutput("stream_ack",  {31'd0, cpu_ack},  32'd1);
            checkOutput("stream_data", {24'd0, cpu_data}, 32'h0A0 + 32'(i));
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();

        // Partial load 55..5A, run raised during the 7th write (5B at 6).
        $display("[TB] partial load");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();
        checkOutput("reload_done_clr", {31'd0, ld_done},  32'd0);
        checkOutput("reload_ready",    {31'd0, ld_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h55 + 8'(i), 1'b0, 4'd0);
            tick();
            checkOutput("part_addr", {28'd0, ram_a}, 32'(i));
            tick();
        end
        applyStimulus(1'b0, 1'b1, 8'h5B, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        checkOutput("part7_write", {31'd0, ram_write}, 32'd1);
        checkOutput("part7_addr",  {28'd0, ram_a},     32'd6);
        tick();
        checkOutput("part_done",     {31'd0, ld_done},   32'd0);
        checkOutput("part_write_off", {31'd0, ram_write}, 32'd0);
        checkOutput("part_ready",    {31'd0, ld_ready},  32'd0);
        expRead = '{8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5A, 8'h5B, 8'hA7};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 4'(i));
            tick();
            tick();
            checkOutput("part_rd_ack",  {31'd0, cpu_ack},  32'd1);
            checkOutput("part_rd_data", {24'd0, cpu_data}, {24'd0, expRead[i]});
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();

        // Reset during LOAD_WR drops the write and restarts the pointer.
        $display("[TB] reset during write and read");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 8'hC0, 1'b0, 4'd0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 8'hC1, 1'b0, 4'd0);
        tick();
        checkOutput("clrwr_pre_addr", {28'd0, ram_a}, 32'd1);
        clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();
        checkOutput("clrwr_write", {31'd0, ram_write}, 32'd0);
        checkOutput("clrwr_prog",  {31'd0, ram_prog},  32'd0);
        clr = 1'b0;
        tick();
        checkOutput("clrwr_ready", {31'd0, ld_ready}, 32'd1);
        applyStimulus(1'b0, 1'b1, 8'hD0, 1'b0, 4'd0);
        tick();
        checkOutput("clrwr_restart", {28'd0, ram_a}, 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();

        // Reset during RUN_RD suppresses the ack.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 4'd3);
        tick();
        checkOutput("clrrd_ce", {31'd0, ram_ce}, 32'd1);
        clr = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();
        checkOutput("clrrd_ack",  {31'd0, cpu_ack},  32'd0);
        checkOutput("clrrd_ce0",  {31'd0, ram_ce},   32'd0);
        checkOutput("clrrd_data", {24'd0, cpu_data}, 32'd0);
        clr = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();
        checkOutput("clrrd_ready", {31'd0, ld_ready}, 32'd1);
        applyStimulus(1'b0, 1'b1, 8'hE0, 1'b0, 4'd0);
        tick();
        checkOutput("clrrd_restart", {28'd0, ram_a},     32'd0);
        checkOutput("clrrd_write",   {31'd0, ram_write}, 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();

        // run dropped during RUN_RD: the read still acks, then LOAD_IDLE.
        $display("[TB] run drop during read");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();
        checkOutput("drop_ack",   {31'd0, cpu_ack},  32'd1);
        checkOutput("drop_data",  {24'd0, cpu_data}, 32'h0E0);
        checkOutput("drop_done",  {31'd0, ld_done},  32'd0);
        checkOutput("drop_ready", {31'd0, ld_ready}, 32'd1);
        applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0, 4'd0);
        tick();
        checkOutput("drop_addr",  {28'd0, ram_a},     32'd0);
        checkOutput("drop_write", {31'd0, ram_write}, 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        tick();
        tick();

        monitorOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sap1_ram_ctrl
